// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and an optional preloaded 0..DEPTH-1 fill.
module fifo_sync #(
    parameter int DWIDTH    = 5,
    parameter int AWIDTH    = 5,
    parameter int AFULL_TH  = (2 ** AWIDTH) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int INIT_FILL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              winc,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rinc,
    output logic [DWIDTH-1:0] rdata,
    output logic              wfull,
    output logic              rempty,
    output logic              afull,
    output logic              aempty,
    output logic [AWIDTH:0]   count,
    output logic              ovf,
    output logic              udf
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE   = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH:0] AFULL_V   = (AWIDTH + 1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AEMPTY_V  = (AWIDTH + 1)'(AEMPTY_TH);
    // Preloaded FIFO starts full: write pointer one lap ahead, count = DEPTH.
    localparam logic [AWIDTH:0] FILL_INIT = (INIT_FILL != 0) ? (AWIDTH + 1)'(DEPTH) : '0;

    logic [AWIDTH:0]   wptr_reg;
    logic [AWIDTH:0]   rptr_reg;
    logic [AWIDTH:0]   count_reg;
    logic              ovf_reg;
    logic              udf_reg;
    logic [DWIDTH-1:0] mem [DEPTH];

    logic wr_ok;
    logic rd_ok;

    assign rempty = (wptr_reg == rptr_reg);
    assign wfull  = (wptr_reg[AWIDTH] != rptr_reg[AWIDTH]) &&
                    (wptr_reg[AWIDTH-1:0] == rptr_reg[AWIDTH-1:0]);
    assign wr_ok  = winc & ~wfull;
    assign rd_ok  = rinc & ~rempty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg  <= FILL_INIT;
            rptr_reg  <= '0;
            count_reg <= FILL_INIT;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else if (flush) begin
            wptr_reg  <= FILL_INIT;
            rptr_reg  <= '0;
            count_reg <= FILL_INIT;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            if (wr_ok) wptr_reg <= wptr_reg + PTR_ONE;
            if (rd_ok) rptr_reg <= rptr_reg + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + PTR_ONE;
                2'b01:   count_reg <= count_reg - PTR_ONE;
                default: count_reg <= count_reg;
            endcase
            if (winc & wfull)  ovf_reg <= 1'b1;
            if (rinc & rempty) udf_reg <= 1'b1;
        end
    end

    generate
        if (INIT_FILL != 0) begin : g_preload
            // Storage must be restorable to the tag sequence, so it carries a reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= DWIDTH'(i);
                end else if (flush) begin
                    for (int i = 0; i < DEPTH; i++) mem[i] <= DWIDTH'(i);
                end else if (wr_ok) begin
                    mem[wptr_reg[AWIDTH-1:0]] <= wdata;
                end
            end
        end else begin : g_plain
            always_ff @(posedge clk) begin
                if (wr_ok && !flush) mem[wptr_reg[AWIDTH-1:0]] <= wdata;
            end
        end
    endgenerate

    assign rdata  = mem[rptr_reg[AWIDTH-1:0]];
    assign count  = count_reg;
    assign afull  = (count_reg >= AFULL_V);
    assign aempty = (count_reg <= AEMPTY_V);
    assign ovf    = ovf_reg;
    assign udf    = udf_reg;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed scoreboard bench for fifo_sync: an 8x8 plain instance and a 32x5 preloaded
// instance, each checked against a queue model after every clock.
module tb_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, flush0, winc0, rinc0;
    logic [7:0] wdata0, rdata0;
    logic       wfull0, rempty0, afull0, aempty0, ovf0, udf0;
    logic [3:0] count0;

    logic       rst1_n, flush1, winc1, rinc1;
    logic [4:0] wdata1, rdata1;
    logic       wfull1, rempty1, afull1, aempty1, ovf1, udf1;
    logic [5:0] count1;

    fifo_sync #(.DWIDTH(8), .AWIDTH(3), .AFULL_TH(6), .AEMPTY_TH(2), .INIT_FILL(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .flush(flush0), .winc(winc0), .wdata(wdata0),
        .rinc(rinc0), .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .afull(afull0),
        .aempty(aempty0), .count(count0), .ovf(ovf0), .udf(udf0)
    );

    fifo_sync #(.DWIDTH(5), .AWIDTH(5), .AFULL_TH(30), .AEMPTY_TH(2), .INIT_FILL(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .flush(flush1), .winc(winc1), .wdata(wdata1),
        .rinc(rinc1), .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .afull(afull1),
        .aempty(aempty1), .count(count1), .ovf(ovf1), .udf(udf1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic       ovf_m0 = 1'b0, udf_m0 = 1'b0;
    logic [4:0] q1[$];
    logic       ovf_m1 = 1'b0, udf_m1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag);
        check({tag, ".count"},  32'(count0),  32'(q0.size()));
        check({tag, ".rempty"}, 32'(rempty0), 32'(q0.size() == 0));
        check({tag, ".wfull"},  32'(wfull0),  32'(q0.size() == 8));
        check({tag, ".afull"},  32'(afull0),  32'(q0.size() >= 6));
        check({tag, ".aempty"}, 32'(aempty0), 32'(q0.size() <= 2));
        check({tag, ".ovf"},    32'(ovf0),    32'(ovf_m0));
        check({tag, ".udf"},    32'(udf0),    32'(udf_m0));
        $display("dut0 %s: count=%0d rempty=%0b wfull=%0b ovf=%0b udf=%0b",
                 tag, count0, rempty0, wfull0, ovf0, udf0);
    endtask

    task automatic chk1(input string tag);
        check({tag, ".count"},  32'(count1),  32'(q1.size()));
        check({tag, ".rempty"}, 32'(rempty1), 32'(q1.size() == 0));
        check({tag, ".wfull"},  32'(wfull1),  32'(q1.size() == 32));
        check({tag, ".afull"},  32'(afull1),  32'(q1.size() >= 30));
        check({tag, ".aempty"}, 32'(aempty1), 32'(q1.size() <= 2));
        check({tag, ".ovf"},    32'(ovf1),    32'(ovf_m1));
        check({tag, ".udf"},    32'(udf1),    32'(udf_m1));
        $display("dut1 %s: count=%0d rempty=%0b wfull=%0b rdata=%0d",
                 tag, count1, rempty1, wfull1, rdata1);
    endtask

    // One clock on dut0; the head is compared before the edge that consumes it.
    task automatic cyc0(input logic w, input logic [7:0] d, input logic r, input logic f);
        logic full, empty;
        winc0 = w; wdata0 = d; rinc0 = r; flush0 = f;
        full  = (q0.size() == 8);
        empty = (q0.size() == 0);
        if (r && !empty && !f) check("dut0.rdata", 32'(rdata0), 32'(q0[0]));
        if (f) begin
            q0.delete();
            ovf_m0 = 1'b0;
            udf_m0 = 1'b0;
        end else begin
            if (w && full)  ovf_m0 = 1'b1;
            if (r && empty) udf_m0 = 1'b1;
            if (r && !empty) void'(q0.pop_front());
            if (w && !full)  q0.push_back(d);
        end
        @(posedge clk);
        #1;
        winc0 = 1'b0; rinc0 = 1'b0; flush0 = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic [4:0] d, input logic r);
        logic full, empty;
        winc1 = w; wdata1 = d; rinc1 = r;
        full  = (q1.size() == 32);
        empty = (q1.size() == 0);
        if (r && !empty) check("dut1.rdata", 32'(rdata1), 32'(q1[0]));
        if (w && full)  ovf_m1 = 1'b1;
        if (r && empty) udf_m1 = 1'b1;
        if (r && !empty) void'(q1.pop_front());
        if (w && !full)  q1.push_back(d);
        @(posedge clk);
        #1;
        winc1 = 1'b0; rinc1 = 1'b0;
    endtask

    initial begin
        rst0_n = 1'b0; flush0 = 1'b0; winc0 = 1'b0; rinc0 = 1'b0; wdata0 = '0;
        rst1_n = 1'b0; flush1 = 1'b0; winc1 = 1'b0; rinc1 = 1'b0; wdata1 = '0;
        for (int i = 0; i < 32; i++) q1.push_back(5'(i));
        repeat (2) @(posedge clk);
        #1;
        chk0("reset");
        chk1("reset");
        check("dut1.rdata_reset", 32'(rdata1), 32'd0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cyc0(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
            chk0("fill");
        end
        cyc0(1'b1, 8'hAA, 1'b1, 1'b0);
        chk0("full_wr_rd");
        for (int i = 0; i < 7; i++) begin
            cyc0(1'b0, 8'h00, 1'b1, 1'b0);
            chk0("drain");
        end
        cyc0(1'b1, 8'h55, 1'b1, 1'b0);
        chk0("empty_wr_rd");
        check("dut0.rdata_55", 32'(rdata0), 32'h55);

        for (int i = 0; i < 3; i++) begin
            cyc0(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
            chk0("prefill4");
        end
        for (int i = 0; i < 20; i++) begin
            cyc0(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            chk0("stream");
        end

        cyc0(1'b1, 8'hC0, 1'b0, 1'b0);
        chk0("count5");
        cyc0(1'b1, 8'hEE, 1'b0, 1'b1);
        chk0("flush");

        for (int i = 0; i < 3; i++) begin
            cyc0(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
            chk0("refill3");
        end
        #3;
        rst0_n = 1'b0;
        #1;
        q0.delete();
        ovf_m0 = 1'b0;
        udf_m0 = 1'b0;
        chk0("async_rst");
        @(negedge clk);
        rst0_n = 1'b1;
        cyc0(1'b1, 8'h42, 1'b0, 1'b0);
        chk0("post_rst_wr");
        cyc0(1'b0, 8'h00, 1'b1, 1'b0);
        chk0("post_rst_rd");

        for (int i = 0; i < 32; i++) begin
            cyc1(1'b0, 5'd0, 1'b1);
            chk1("preload_rd");
        end
        cyc1(1'b1, 5'd7, 1'b0);
        chk1("write7");
        check("dut1.rdata_7", 32'(rdata1), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
